// File: rtl/shadow_chain.sv
// Shadow-state snapshot feeder: captures din on a strobe and shifts it out LSB-first
// under chain_en grant. Define SHADOW_CHAIN_PARITY_EN to append an even-parity bit.
module shadow_chain #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             capture,
  input  logic [WIDTH-1:0] din,
  input  logic             chain_en,
  output logic             chain_out,
  output logic             chain_status,
  output logic             overrun,
  input  logic             clr_overrun
);

`ifdef SHADOW_CHAIN_PARITY_EN
  localparam int SH_W = WIDTH + 1;
`else
  localparam int SH_W = WIDTH;
`endif

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [SH_W-1:0]  shreg_reg, shreg_next;
  logic [SH_W-1:0]  load_val;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             overrun_reg, overrun_next;
  logic             last_shift;

`ifdef SHADOW_CHAIN_PARITY_EN
  // Running XOR across din; the final tap is the even-parity bit sent after the MSB.
  logic [WIDTH-1:0] par_chain;
  assign par_chain[0] = din[0];
  genvar gi;
  for (gi = 1; gi < WIDTH; gi++) begin : g_par
    assign par_chain[gi] = par_chain[gi-1] ^ din[gi];
  end
  assign load_val = {par_chain[WIDTH-1], din};
`else
  assign load_val = din;
`endif

  assign last_shift = (state_reg == SHIFT) && chain_en && (cnt_reg == CNT_W'(1));

  always_comb begin
    state_next   = state_reg;
    shreg_next   = shreg_reg;
    cnt_next     = cnt_reg;
    overrun_next = overrun_reg;
    if (clr_overrun) overrun_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (capture) begin
          shreg_next = load_val;
          cnt_next   = CNT_W'(SH_W);
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (chain_en) begin
          shreg_next = shreg_reg >> 1;
          cnt_next   = cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) state_next = IDLE;
        end
        // A capture coinciding with the final shift reloads seamlessly; any other
        // capture while draining is dropped and flagged (set beats clear).
        if (capture) begin
          if (last_shift) begin
            shreg_next = load_val;
            cnt_next   = CNT_W'(SH_W);
            state_next = SHIFT;
          end else begin
            overrun_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      shreg_reg   <= '0;
      cnt_reg     <= '0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shreg_reg   <= shreg_next;
      cnt_reg     <= cnt_next;
      overrun_reg <= overrun_next;
    end
  end

  assign chain_status = (state_reg == SHIFT);
  assign chain_out    = (state_reg == SHIFT) && shreg_reg[0];
  assign overrun      = overrun_reg;

endmodule

// File: tb/tb_shadow_chain.sv
// Directed bench for shadow_chain (WIDTH=16): a vector table plus hand-written
// sequences for gapped grants, back-to-back capture and mid-shift reset.
module tb_shadow_chain;

`ifdef SHADOW_CHAIN_PARITY_EN
  localparam int NB = 17;
`else
  localparam int NB = 16;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        capture = 1'b0;
  logic [15:0] din = '0;
  logic        chain_en = 1'b0;
  logic        clr_overrun = 1'b0;
  logic        chain_out, chain_status, overrun;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  typedef struct {
    logic        cap;
    logic [15:0] d;
    logic        en;
    logic        clr;
    logic        eo;
    logic        es;
    logic        eov;
  } vec_t;

  vec_t vecs[$];

  shadow_chain #(.WIDTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .capture      (capture),
    .din          (din),
    .chain_en     (chain_en),
    .chain_out    (chain_out),
    .chain_status (chain_status),
    .overrun      (overrun),
    .clr_overrun  (clr_overrun)
  );

  always #5 clk = ~clk;

  // Bit k of the serial stream for snapshot d: data bits, then parity at k==16.
  function automatic logic exp_bit(logic [15:0] d, int k);
    logic [15:0] t;
    if (k >= 16) return ^d;
    t = d >> k;
    return t[0];
  endfunction

  task automatic check(string name, logic eo, logic es, logic eov);
    tot_cnt++;
    if (chain_out === eo && chain_status === es && overrun === eov) begin
      pass_cnt++;
      $display("ok   %s: out=%0b status=%0b overrun=%0b", name, chain_out, chain_status, overrun);
    end else begin
      $display("FAIL %s: got out=%0b status=%0b overrun=%0b, want out=%0b status=%0b overrun=%0b",
               name, chain_out, chain_status, overrun, eo, es, eov);
    end
  endtask

  task automatic step(logic cap, logic [15:0] d, logic en, logic clr);
    capture     = cap;
    din         = d;
    chain_en    = en;
    clr_overrun = clr;
    @(posedge clk);
    #1;
    capture     = 1'b0;
    chain_en    = 1'b0;
    clr_overrun = 1'b0;
  endtask

  task automatic add(logic cap, logic [15:0] d, logic en, logic clr, logic eo, logic es, logic eov);
    vec_t v;
    v.cap = cap; v.d = d; v.en = en; v.clr = clr;
    v.eo = eo; v.es = es; v.eov = eov;
    vecs.push_back(v);
  endtask

  initial begin
    int g;
    int cyc;

    // Idle grants are ignored.
    for (int i = 0; i < 5; i++) add(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // Continuous drain of A5C3 (chain_en high during capture too).
    add(1'b1, 16'hA5C3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= NB; k++)
      add(1'b0, 16'h0, 1'b1, 1'b0, (k < NB) ? exp_bit(16'hA5C3, k) : 1'b0, k < NB, 1'b0);
    // Overrun: capture 0001, 3 shifts, rejected FFFF capture, clear, set-wins.
    add(1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 3; k++) add(1'b0, 16'h0, 1'b1, 1'b0, exp_bit(16'h0001, k), 1'b1, 1'b0);
    add(1'b1, 16'hFFFF, 1'b0, 1'b0, exp_bit(16'h0001, 3), 1'b1, 1'b1);
    add(1'b0, 16'h0, 1'b0, 1'b1, exp_bit(16'h0001, 3), 1'b1, 1'b0);
    add(1'b1, 16'hFFFF, 1'b0, 1'b1, exp_bit(16'h0001, 3), 1'b1, 1'b1);
    add(1'b0, 16'h0, 1'b0, 1'b1, exp_bit(16'h0001, 3), 1'b1, 1'b0);
    for (int k = 4; k <= NB; k++)
      add(1'b0, 16'h0, 1'b1, 1'b0, (k < NB) ? exp_bit(16'h0001, k) : 1'b0, k < NB, 1'b0);

    // Reset and post-reset idle state.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset", 1'b0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      step(vecs[i].cap, vecs[i].d, vecs[i].en, vecs[i].clr);
      check($sformatf("vec%0d", i), vecs[i].eo, vecs[i].es, vecs[i].eov);
    end

    // Gapped grants: same bits, status held through gaps.
    step(1'b1, 16'hA5C3, 1'b0, 1'b0);
    check("gap_cap", 1'b1, 1'b1, 1'b0);
    g = 0;
    cyc = 0;
    while (g < NB && cyc < 200) begin
      step(1'b0, 16'h0, (cyc % 2) == 0, 1'b0);
      if ((cyc % 2) == 0) g++;
      cyc++;
      check($sformatf("gap_c%0d", cyc), (g < NB) ? exp_bit(16'hA5C3, g) : 1'b0, g < NB, 1'b0);
    end
    tot_cnt++;
    if (cyc == 2 * NB - 1) pass_cnt++;
    else $display("FAIL gap_len: got %0d cycles, want %0d", cyc, 2 * NB - 1);

    // Back-to-back capture on the final grant.
    step(1'b1, 16'h00FF, 1'b0, 1'b0);
    check("b2b_cap", 1'b1, 1'b1, 1'b0);
    for (int k = 1; k < NB; k++) begin
      step(1'b0, 16'h0, 1'b1, 1'b0);
      check($sformatf("b2b_a%0d", k), exp_bit(16'h00FF, k), 1'b1, 1'b0);
    end
    step(1'b1, 16'hFF00, 1'b1, 1'b0);
    check("b2b_reload", exp_bit(16'hFF00, 0), 1'b1, 1'b0);
    for (int k = 1; k <= NB; k++) begin
      step(1'b0, 16'h0, 1'b1, 1'b0);
      check($sformatf("b2b_b%0d", k), (k < NB) ? exp_bit(16'hFF00, k) : 1'b0, k < NB, 1'b0);
    end

    // Mid-shift asynchronous reset, then a fresh full drain.
    step(1'b1, 16'h1234, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) step(1'b0, 16'h0, 1'b1, 1'b0);
    check("pre_rst", exp_bit(16'h1234, 5), 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("rst_async", 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    check("rst_release", 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0007, 1'b0, 1'b0);
    check("post_cap", 1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= NB; k++) begin
      step(1'b0, 16'h0, 1'b1, 1'b0);
      check($sformatf("post_%0d", k), (k < NB) ? exp_bit(16'h0007, k) : 1'b0, k < NB, 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/shadow_chain.md
Name: shadow_chain

Overview:
- Upstream feeder for one input lane of the chain controller.
- Snapshots a parallel WIDTH-bit shadow of design state on a capture strobe, then serialises it LSB-first onto a single chain bit.
- Advances only when the controller grants the lane; raises status while bits remain.
- One instance per controller chain input: chain_status drives cin_status[i], chain_out drives cin[i], cin_en[i] drives chain_en.

Parameters:
WIDTH, 16, number of shadow bits captured per snapshot (>=2)
CNT_W, $clog2(WIDTH+2), width of internal bit counter

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
capture  input  1  single-cycle strobe: snapshot din
din  input  WIDTH  parallel shadow data sampled on capture
chain_en  input  1  shift grant from chain controller
chain_out  output  1  current serial bit (LSB first)
chain_status  output  1  1 = valid bit present on chain_out
overrun  output  1  sticky: capture arrived while previous snapshot not drained
clr_overrun  input  1  synchronous clear of overrun

Behaviour:
- Reset (async, rst=1): shift register 0, counter 0, state IDLE, chain_out=0, chain_status=0, overrun=0.
- States: IDLE (nothing pending) and SHIFT (bits remaining). chain_status=1 exactly in SHIFT.
- chain_out = shreg[0] in SHIFT, forced 0 in IDLE. It is combinational from registers with no input-to-output path.
- IDLE + capture:
  - Next cycle: shreg<=din, cnt<=WIDTH, state SHIFT.
  - Latency capture -> chain_status=1 is one cycle.
- SHIFT + chain_en:
  - Consumer takes chain_out this cycle.
  - shreg<=shreg>>1 (MSB filled 0), cnt<=cnt-1.
  - When cnt==1, the next state is IDLE.
- SHIFT + !chain_en: hold all state. No timeout.
- chain_en in IDLE: ignored, no state change.
- Capture in SHIFT when not (chain_en && cnt==1):
  - Snapshot rejected; shreg and cnt unchanged.
  - overrun<=1 next cycle.
- Capture in the same cycle as the final shift (chain_en && cnt==1):
  - Accepted, no overrun.
  - Loads din, cnt<=WIDTH, stays in SHIFT, so chain_status stays high continuously.
- overrun:
  - Sticky.
  - Cleared on the cycle after clr_overrun=1.
  - If clr_overrun and a new overrun event occur together, set wins.
- A full drain takes exactly WIDTH granted cycles. Non-granted cycles may be interleaved arbitrarily.
- Reset mid-shift: immediate abort; the remaining bits are lost and all outputs return to reset values.
- Counter never underflows; cnt==0 iff IDLE.

Optional Feature:
- Macro SHADOW_CHAIN_PARITY_EN.
- When defined:
  - An extra even-parity bit (XOR of the captured din) is emitted after the MSB.
  - Drain length becomes WIDTH+1 granted cycles; cnt loads WIDTH+1.
  - Parity is computed at capture and stored as shreg bit WIDTH (register WIDTH+1 wide).
  - The final-shift/capture overlap rule applies at cnt==1 of the extended length.
- When undefined: no parity bit, register WIDTH wide, drain length WIDTH.

Test Plan:
- Reset then idle, WIDTH=16: after rst deassert, chain_status=0, chain_out=0, overrun=0. chain_en=1 for 5 cycles -> no change.
- capture with din=16'hA5C3, chain_en held 1 -> chain_status=1 from next cycle for exactly 16 cycles. chain_out sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, then status=0.
- Same din, chain_en toggling 1,0,1,0… -> identical bit sequence. Status held across gaps; drain completes after 16 grants (31 cycles).
- Overrun: capture 16'h0001, shift 3 bits, capture 16'hFFFF:
  - overrun=1 next cycle; remaining bits still come from 16'h0001.
  - clr_overrun pulse -> overrun=0.
- Back-to-back: capture 16'h00FF, then capture 16'hFF00 in the cycle of the 16th grant:
  - No overrun; chain_status never drops.
  - Next 16 bits are 8 zeros then 8 ones.
- Mid-shift reset after 5 bits: outputs 0 immediately. New capture after reset drains all 16 fresh bits. With SHADOW_CHAIN_PARITY_EN, din=16'h0007 -> 17th bit=1.
